// File: rtl/voice_mixer_if.sv
// Sample/register bus of voice_mixer: sample strobe, packed voice samples,
// register access port and the mixed-sample output.
interface voice_mixer_if #(
    parameter int NUM_VOICES   = 8,
    parameter int SAMPLE_WIDTH = 24
);
    logic                                 i_SampleStrobe;
    logic [NUM_VOICES*SAMPLE_WIDTH-1:0]   i_VoiceSamples;
    logic [11:0]                          i_RegisterNumber;
    logic [23:0]                          i_RegisterValue;
    logic                                 i_RegisterWriteEnable;
    logic                                 i_RegisterReadEnable;
    logic [23:0]                          o_RegisterReadData;
    logic                                 o_RegisterReadValid;
    logic signed [SAMPLE_WIDTH-1:0]       o_Sample;
    logic                                 o_SampleValid;
    logic                                 o_Busy;

    modport slave (
        input  i_SampleStrobe, i_VoiceSamples, i_RegisterNumber, i_RegisterValue,
               i_RegisterWriteEnable, i_RegisterReadEnable,
        output o_RegisterReadData, o_RegisterReadValid, o_Sample, o_SampleValid, o_Busy
    );

    modport master (
        output i_SampleStrobe, i_VoiceSamples, i_RegisterNumber, i_RegisterValue,
               i_RegisterWriteEnable, i_RegisterReadEnable,
        input  o_RegisterReadData, o_RegisterReadValid, o_Sample, o_SampleValid, o_Busy
    );
endinterface

// File: rtl/voice_mixer.sv
// Serial per-voice gain/mute mixer with master attenuation, saturation and a register block.
// Optional build macro VOICE_MIXER_ROUND_EN: round half up before the final shift.
module voice_mixer #(
    parameter int NUM_VOICES   = 8,
    parameter int SAMPLE_WIDTH = 24,
    parameter int GAIN_WIDTH   = 8
) (
    input  logic          i_Clock,
    input  logic          i_Reset_n,
    voice_mixer_if.slave  bus
);
    localparam int ACC_W  = SAMPLE_WIDTH + GAIN_WIDTH + $clog2(NUM_VOICES) + 2;
    localparam int PROD_W = SAMPLE_WIDTH + GAIN_WIDTH + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_SCALE} state_t;

    logic [5:0] voice_id, reg_id;
    assign voice_id = bus.i_RegisterNumber[11:6];
    assign reg_id   = bus.i_RegisterNumber[5:0];

    logic [NUM_VOICES*GAIN_WIDTH-1:0] gain_all;
    logic [NUM_VOICES-1:0]            mute_all;
    logic [2:0]                       master_shift_reg;
    logic                             overrun_reg, clipped_reg;
    logic                             unused_wdata;
    assign unused_wdata = ^bus.i_RegisterValue;

    for (genvar gi = 1; gi <= NUM_VOICES; gi++) begin : g_voice
        logic [GAIN_WIDTH-1:0] gain_reg;
        logic                  mute_reg;
        logic                  sel;
        assign sel = bus.i_RegisterWriteEnable && (voice_id == 6'(gi));
        always_ff @(posedge i_Clock or negedge i_Reset_n) begin
            if (!i_Reset_n) begin
                gain_reg <= GAIN_WIDTH'(32);
                mute_reg <= 1'b0;
            end else if (sel && reg_id == 6'h08) begin
                gain_reg <= bus.i_RegisterValue[GAIN_WIDTH-1:0];
            end else if (sel && reg_id == 6'h09) begin
                mute_reg <= bus.i_RegisterValue[0];
            end
        end
        assign gain_all[gi*GAIN_WIDTH-1 -: GAIN_WIDTH] = gain_reg;
        assign mute_all[gi-1] = mute_reg;
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n)
            master_shift_reg <= 3'd0;
        else if (bus.i_RegisterWriteEnable && bus.i_RegisterNumber == 12'h000)
            master_shift_reg <= bus.i_RegisterValue[2:0];
    end

    // Readback mux; registered below so a same-cycle write is not yet visible.
    logic [23:0] rd_mux;
    always_comb begin
        rd_mux = '0;
        if (voice_id == 6'd0) begin
            if (reg_id == 6'h00)      rd_mux = 24'(master_shift_reg);
            else if (reg_id == 6'h01) rd_mux = {22'd0, clipped_reg, overrun_reg};
        end else begin
            for (int v = 1; v <= NUM_VOICES; v++) begin
                if (voice_id == 6'(v)) begin
                    if (reg_id == 6'h08)      rd_mux = 24'(gain_all[v*GAIN_WIDTH-1 -: GAIN_WIDTH]);
                    else if (reg_id == 6'h09) rd_mux = {23'd0, mute_all[v-1]};
                end
            end
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            bus.o_RegisterReadData  <= '0;
            bus.o_RegisterReadValid <= 1'b0;
        end else begin
            bus.o_RegisterReadValid <= bus.i_RegisterReadEnable;
            if (bus.i_RegisterReadEnable)
                bus.o_RegisterReadData <= rd_mux;
        end
    end

    state_t                           state_reg;
    logic [5:0]                       index_reg;
    logic signed [ACC_W-1:0]          acc_reg;
    logic [NUM_VOICES*SAMPLE_WIDTH-1:0] snap_samples_reg;
    logic [NUM_VOICES*GAIN_WIDTH-1:0] snap_gain_reg;
    logic [NUM_VOICES-1:0]            snap_mute_reg;
    logic [2:0]                       snap_shift_reg;

    logic signed [SAMPLE_WIDTH-1:0]   cur_sample;
    logic [GAIN_WIDTH-1:0]            cur_gain;
    logic                             cur_mute;
    always_comb begin
        cur_sample = '0;
        cur_gain   = '0;
        cur_mute   = 1'b1;
        for (int v = 1; v <= NUM_VOICES; v++) begin
            if (index_reg == 6'(v)) begin
                cur_sample = snap_samples_reg[v*SAMPLE_WIDTH-1 -: SAMPLE_WIDTH];
                cur_gain   = snap_gain_reg[v*GAIN_WIDTH-1 -: GAIN_WIDTH];
                cur_mute   = snap_mute_reg[v-1];
            end
        end
    end

    logic signed [PROD_W-1:0] prod_raw, prod;
    logic signed [ACC_W-1:0]  acc_sum;
    assign prod_raw = cur_sample * $signed({1'b0, cur_gain});
    assign prod     = cur_mute ? '0 : prod_raw;
    assign acc_sum  = acc_reg + $signed({{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod});

    logic [7:0]                     shamt;
    logic signed [ACC_W-1:0]        acc_biased, acc_shift;
    logic [ACC_W-SAMPLE_WIDTH:0]    upper;
    logic                           fits;
    logic signed [SAMPLE_WIDTH-1:0] sat_value;
    assign shamt = 8'(GAIN_WIDTH) + 8'(snap_shift_reg);
`ifdef VOICE_MIXER_ROUND_EN
    assign acc_biased = acc_reg + (ACC_W'(1) << (shamt - 8'd1));
`else
    assign acc_biased = acc_reg;
`endif
    assign acc_shift = acc_biased >>> shamt;
    // The shifted value fits when every bit above the output sign bit matches it.
    assign upper     = acc_shift[ACC_W-1:SAMPLE_WIDTH-1];
    assign fits      = (&upper) | ~(|upper);
    assign sat_value = fits ? acc_shift[SAMPLE_WIDTH-1:0]
                            : {acc_shift[ACC_W-1], {(SAMPLE_WIDTH-1){~acc_shift[ACC_W-1]}}};

    logic status_rd, overrun_set, clip_set;
    assign status_rd   = bus.i_RegisterReadEnable && bus.i_RegisterNumber == 12'h001;
    assign overrun_set = bus.i_SampleStrobe && state_reg != ST_IDLE;
    assign clip_set    = state_reg == ST_SCALE && !fits;

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_reg        <= ST_IDLE;
            index_reg        <= '0;
            acc_reg          <= '0;
            snap_samples_reg <= '0;
            snap_gain_reg    <= '0;
            snap_mute_reg    <= '0;
            snap_shift_reg   <= '0;
            overrun_reg      <= 1'b0;
            clipped_reg      <= 1'b0;
            bus.o_Sample     <= '0;
            bus.o_SampleValid <= 1'b0;
            bus.o_Busy       <= 1'b0;
        end else begin
            bus.o_SampleValid <= 1'b0;
            // A status event in the same cycle as its read keeps the bit set.
            overrun_reg <= overrun_set | (overrun_reg & ~status_rd);
            clipped_reg <= clip_set    | (clipped_reg & ~status_rd);
            case (state_reg)
                ST_IDLE: begin
                    if (bus.i_SampleStrobe) begin
                        snap_samples_reg <= bus.i_VoiceSamples;
                        snap_gain_reg    <= gain_all;
                        snap_mute_reg    <= mute_all;
                        snap_shift_reg   <= master_shift_reg;
                        acc_reg          <= '0;
                        index_reg        <= 6'd1;
                        bus.o_Busy       <= 1'b1;
                        state_reg        <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    acc_reg <= acc_sum;
                    if (index_reg == 6'(NUM_VOICES))
                        state_reg <= ST_SCALE;
                    else
                        index_reg <= index_reg + 6'd1;
                end
                ST_SCALE: begin
                    bus.o_Sample      <= sat_value;
                    bus.o_SampleValid <= 1'b1;
                    bus.o_Busy        <= 1'b0;
                    state_reg         <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_voice_mixer.sv
// Directed bench for voice_mixer: expected samples/read data are queued at issue
// time and a negedge monitor pops and compares whenever the DUT presents data.
module tb_voice_mixer;
    localparam int NV = 8;
    localparam int SW = 24;
`ifdef VOICE_MIXER_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    typedef struct { logic [SW-1:0] value; int t_edge; string name; } smp_t;
    typedef struct { logic [23:0] value; string name; } rd_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    smp_t smp_q[$];
    rd_t  rd_q[$];

    voice_mixer_if #(.NUM_VOICES(NV), .SAMPLE_WIDTH(SW)) bus ();

    voice_mixer #(.NUM_VOICES(NV), .SAMPLE_WIDTH(SW), .GAIN_WIDTH(8)) dut (
        .i_Clock   (clk),
        .i_Reset_n (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: a mix strobed into edge T must be sampled valid by edge T+NV+2,
    // i.e. be visible just after edge T+NV+1.
    always @(negedge clk) begin
        if (bus.o_SampleValid) begin
            total++;
            if (smp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_valid: got sample %h, required no pulse (cycle %0d)", bus.o_Sample, cyc);
            end else begin
                smp_t e;
                e = smp_q.pop_front();
                if (bus.o_Sample !== e.value || cyc - e.t_edge != NV + 1) begin
                    bad++;
                    $display("FAIL %s: got %h after %0d edges, required %h after %0d edges",
                             e.name, bus.o_Sample, cyc - e.t_edge, e.value, NV + 1);
                end else
                    $display("mix %s: sample %h ok", e.name, bus.o_Sample);
            end
        end
        if (bus.o_RegisterReadValid) begin
            total++;
            if (rd_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_read: got %h, required no read valid", bus.o_RegisterReadData);
            end else begin
                rd_t r;
                r = rd_q.pop_front();
                if (bus.o_RegisterReadData !== r.value) begin
                    bad++;
                    $display("FAIL %s: got %h, required %h", r.name, bus.o_RegisterReadData, r.value);
                end else
                    $display("read %s: %h ok", r.name, bus.o_RegisterReadData);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All tasks enter and leave 1ns after a rising edge.
    task automatic wr(input logic [5:0] vid, input logic [5:0] rid, input logic [23:0] val);
        bus.i_RegisterNumber      = {vid, rid};
        bus.i_RegisterValue       = val;
        bus.i_RegisterWriteEnable = 1'b1;
        @(posedge clk); #1;
        bus.i_RegisterWriteEnable = 1'b0;
    endtask

    task automatic rd(input logic [5:0] vid, input logic [5:0] rid, input logic [23:0] exp, input string name);
        rd_t r;
        r.value = exp; r.name = name;
        rd_q.push_back(r);
        bus.i_RegisterNumber     = {vid, rid};
        bus.i_RegisterReadEnable = 1'b1;
        @(posedge clk); #1;
        bus.i_RegisterReadEnable = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic set_voice(input int v, input logic [SW-1:0] val);
        bus.i_VoiceSamples[v*SW-1 -: SW] = val;
    endtask

    task automatic set_all(input logic [SW-1:0] val);
        for (int v = 1; v <= NV; v++) set_voice(v, val);
    endtask

    task automatic strobe();
        bus.i_SampleStrobe = 1'b1;
        @(posedge clk); #1;
        bus.i_SampleStrobe = 1'b0;
    endtask

    task automatic launch(input logic [SW-1:0] exp, input string name);
        smp_t e;
        e.value = exp; e.t_edge = cyc + 1; e.name = name;
        smp_q.push_back(e);
        strobe();
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (smp_q.size() != 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (smp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL %s_timeout: got no valid pulse in 40 cycles, required one", name);
            smp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic mix(input logic [SW-1:0] exp, input string name);
        launch(exp, name);
        wait_done(name);
    endtask

    task automatic check(input logic [31:0] got, input logic [31:0] req, input string name);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end else
            $display("check %s: %h ok", name, got);
    endtask

    initial begin
        bus.i_SampleStrobe = 1'b0;
        bus.i_VoiceSamples = '0;
        bus.i_RegisterNumber = '0;
        bus.i_RegisterValue = '0;
        bus.i_RegisterWriteEnable = 1'b0;
        bus.i_RegisterReadEnable = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check(32'(bus.o_Sample), 32'h0, "reset_sample");
        check(32'(bus.o_Busy), 32'h0, "reset_busy");
        check(32'(bus.o_SampleValid), 32'h0, "reset_valid");
        rd(6'd1, 6'h08, 24'h000020, "gain1_reset");
        rd(6'd8, 6'h09, 24'h000000, "mute8_reset");
        rd(6'd0, 6'h00, 24'h000000, "shift_reset");
        rd(6'd0, 6'h01, 24'h000000, "status_reset");

        // Default gains 1/8 each, eight equal voices
        set_all(24'h100000);
        launch(24'h100000, "default_mix");
        check(32'(bus.o_Busy), 32'h1, "busy_in_mix");
        wait_done("default_mix");
        rd(6'd0, 6'h01, 24'h000000, "status_after_default");

        // Full gain: positive and negative saturation
        for (int v = 1; v <= NV; v++) wr(6'(v), 6'h08, 24'h0000FF);
        set_all(24'h7FFFFF);
        mix(24'h7FFFFF, "clip_pos");
        rd(6'd0, 6'h01, 24'h000002, "status_clipped");
        rd(6'd0, 6'h01, 24'h000000, "status_cleared");
        set_all(24'h800000);
        mix(24'h800000, "clip_neg");
        rd(6'd0, 6'h01, 24'h000002, "status_clipped_neg");

        // Single voice at half gain, then master attenuation
        for (int v = 2; v <= NV; v++) wr(6'(v), 6'h09, 24'h000001);
        wr(6'd1, 6'h08, 24'h000080);
        set_voice(1, 24'h000100);
        mix(24'h000080, "single_half");
        wr(6'd0, 6'h00, 24'h000001);
        rd(6'd0, 6'h00, 24'h000001, "shift_readback");
        mix(24'h000040, "master_shift1");
        wr(6'd0, 6'h00, 24'h000000);

        // Truncation versus rounding: 3*128/256=1.5, -3*128/256=-1.5
        set_voice(1, 24'h000003);
        mix(ROUND ? 24'h000002 : 24'h000001, "frac_pos");
        set_voice(1, 24'hFFFFFD);
        mix(ROUND ? 24'hFFFFFF : 24'hFFFFFE, "frac_neg");

        // Register readback and unmapped addresses
        wr(6'd3, 6'h08, 24'h00005A);
        rd(6'd3, 6'h08, 24'h00005A, "gain3_readback");
        rd(6'd9, 6'h08, 24'h000000, "unmapped_voice9");
        rd(6'd0, 6'h02, 24'h000000, "unmapped_global");
        rd(6'd2, 6'h09, 24'h000001, "mute2_readback");

        // Write during a mix only affects the next snapshot
        set_voice(1, 24'h000200);
        launch(24'h000100, "old_gain_in_flight");
        wr(6'd1, 6'h08, 24'h000040);
        wait_done("old_gain_in_flight");
        mix(24'h000080, "new_gain_next");
        wr(6'd1, 6'h08, 24'h000080);

        // Second strobe three cycles into a mix: one pulse, Overrun set
        launch(24'h000100, "overrun_mix");
        repeat (2) @(posedge clk);
        #1;
        strobe();
        wait_done("overrun_mix");
        repeat (15) @(posedge clk);
        #1;
        rd(6'd0, 6'h01, 24'h000001, "status_overrun");

        // Asynchronous reset mid-mix: no pulse, everything back to defaults
        strobe();
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check(32'(bus.o_Sample), 32'h0, "midreset_sample");
        check(32'(bus.o_Busy), 32'h0, "midreset_busy");
        check(32'(bus.o_SampleValid), 32'h0, "midreset_valid");
        check(32'(bus.o_RegisterReadData), 32'h0, "midreset_readdata");
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        rd(6'd1, 6'h08, 24'h000020, "gain1_after_reset");
        rd(6'd0, 6'h01, 24'h000000, "status_after_reset");

        repeat (5) @(posedge clk);
        #1;
        if (rd_q.size() != 0) begin
            total++; bad++;
            $display("FAIL read_pending: got %0d reads without valid, required 0", rd_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/voice_mixer.md
Name: voice_mixer

Overview:
Parametrised successor to the fixed eight-voice "/8 and add" output stage. It sits between the voice instances and the sample output. On each sample strobe it snapshots every voice sample and applies a programmable per-voice gain and mute. It accumulates the voices serially, one per cycle, then applies master attenuation and saturation, and presents one registered output sample with a valid pulse. It owns its own register block, with readback and sticky status.

Parameters:
NUM_VOICES, 8, number of voice inputs (1..63)
SAMPLE_WIDTH, 24, signed sample width in and out
GAIN_WIDTH, 8, unsigned per-voice gain width; unity ≈ 2^GAIN_WIDTH

Ports:
i_Clock  in  1  clock
i_Reset_n  in  1  asynchronous, active-low reset
i_SampleStrobe  in  1  start-of-sample-period pulse
i_VoiceSamples  in  NUM_VOICES*SAMPLE_WIDTH  packed signed samples; voice v at bits [v*SAMPLE_WIDTH-1 -: SAMPLE_WIDTH], v=1..NUM_VOICES
i_RegisterNumber  in  12  {voiceID[5:0], reg[5:0]}
i_RegisterValue  in  24  write data
i_RegisterWriteEnable  in  1  write strobe
i_RegisterReadEnable  in  1  read strobe
o_RegisterReadData  out  24  read data
o_RegisterReadValid  out  1  read data valid
o_Sample  out  SAMPLE_WIDTH  mixed signed sample
o_SampleValid  out  1  one-cycle pulse when o_Sample updates
o_Busy  out  1  mix in progress

Behaviour:
- Register map, voiceID 1..NUM_VOICES:
  - reg 6'h08 Gain[GAIN_WIDTH-1:0], reset 0x20 (1/8, same as previous mix).
  - reg 6'h09 Mute[0], reset 0.
- Register map, voiceID 0:
  - reg 6'h00 MasterShift[2:0], reset 0.
  - reg 6'h01 Status, read-only. Bit0 Overrun, bit1 Clipped; both sticky, cleared by reading.
- Register map, everything else: writes are ignored and reads return 0.
- Reads:
  - Data appears in the cycle after i_RegisterReadEnable, with o_RegisterReadValid high for 1 cycle.
  - A read and a write to the same address in the same cycle return the old value.
  - If a status event and a status read occur in the same cycle, the event wins and the bit stays set.
- FSM IDLE -> ACCUM -> SCALE -> IDLE.
  - IDLE: if i_SampleStrobe, snapshot all samples, gains and mutes; clear the accumulator; index=1; go to ACCUM.
  - ACCUM: acc += Mute[index] ? 0 : sample[index] * $signed({1'b0,gain[index]}). After index==NUM_VOICES, go to SCALE.
  - SCALE: r = acc >>> (GAIN_WIDTH + MasterShift), arithmetic shift.
    - Saturate r to [-2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)-1].
    - Set Clipped if saturation occurred.
    - Register o_Sample and pulse o_SampleValid.
    - Go to IDLE.
- Accumulator width: SAMPLE_WIDTH+GAIN_WIDTH+$clog2(NUM_VOICES)+2; the accumulator never overflows internally.
- Latency: strobe sampled at edge T gives o_SampleValid high in cycle T+NUM_VOICES+2.
- o_Busy is high in ACCUM and SCALE.
- Strobe while busy: the strobe is ignored, Overrun is set, and the current mix completes unaffected.
- Register writes during a mix take effect at the next snapshot only.
- o_Sample holds its value between valid pulses.
- Reset (asynchronous, any state, including mid-mix):
  - FSM to IDLE.
  - o_Sample=0, o_SampleValid=0, o_Busy=0, o_RegisterReadData=0, o_RegisterReadValid=0.
  - Accumulator 0, status 0, registers to their reset values.
  - No o_SampleValid pulse is produced for the aborted mix.

Optional Feature:
VOICE_MIXER_ROUND_EN
- Defined: SCALE adds 2^(GAIN_WIDTH+MasterShift-1) to acc before the shift (round half up), then saturates.
- Undefined: plain arithmetic-shift truncation (toward -inf).
- Latency is identical in both builds.

Test Plan:
- Defaults (gains 0x20), all voices 24'h100000, strobe -> o_Sample=24'h100000, valid at T+10, Clipped=0.
- All gains 0xFF, all voices 24'h7FFFFF -> o_Sample=24'h7FFFFF, Status reads 2'b10. All voices 24'h800000 -> o_Sample=24'h800000. Second status read returns 0.
- Voices 2..8 muted, voice1 gain 0x80, sample 24'h000100 -> 24'h000080. MasterShift=1 -> 24'h000040.
- Voice1 only, gain 0x80, sample 3 -> 1 without VOICE_MIXER_ROUND_EN, 2 with it. Sample -3 -> -2 without, -1 with.
- Strobe again 3 cycles after first strobe -> one valid pulse only at T+10, Status bit0=1. Assert i_Reset_n low at T+5 -> outputs 0, no valid pulse, Gain readback 0x20.
- Write Gain voice 3 = 0x5A, read it back -> o_RegisterReadData=24'h00005A one cycle later with valid. Read address {6'd9,6'h08} -> 0.
